// File: rtl/lsu_ctrl_if.sv
// CPU request/response and data-memory bus for the load/store unit.
// slave = the LSU side, master = the CPU / memory environment side.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write, mem_read
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write, mem_read
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Big-endian load/store unit: sub-word loads with extension, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses; otherwise low address bits are forced aligned.
module lsu_ctrl #(
  parameter int unsigned MEM_WORDS = 256
) (
  input logic       clk,
  input logic       reset,
  lsu_ctrl_if.slave bus
);
  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
  localparam logic [1:0]  SZ_BYTE     = 2'b00;
  localparam logic [1:0]  SZ_HALF     = 2'b01;
  localparam logic [1:0]  SZ_WORD     = 2'b10;
  localparam logic [1:0]  SZ_RSVD     = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

  state_t      state;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [15:0] wdata_q;

  logic        misaligned;
  logic        req_err;
  logic [1:0]  req_off;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  // Request decode: error classification and the aligned lane offset.
  always_comb begin
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                 ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`endif
    req_err = (bus.req_size == SZ_RSVD) ||
              ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS_W) ||
              misaligned;
    case (bus.req_size)
      SZ_BYTE: req_off = bus.req_addr[1:0];
      SZ_HALF: req_off = {bus.req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

  // Lane select on the live read word; offset 0 is the most significant lane.
  always_comb begin
    case (off_q)
      2'b00:   rd_byte = bus.mem_rdata[31:24];
      2'b01:   rd_byte = bus.mem_rdata[23:16];
      2'b10:   rd_byte = bus.mem_rdata[15:8];
      default: rd_byte = bus.mem_rdata[7:0];
    endcase
    rd_half = off_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];

    case (size_q)
      SZ_BYTE: load_data = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: load_data = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_data = bus.mem_rdata;
    endcase

    merge_data = bus.mem_rdata;
    if (size_q == SZ_BYTE) begin
      case (off_q)
        2'b00:   merge_data[31:24] = wdata_q[7:0];
        2'b01:   merge_data[23:16] = wdata_q[7:0];
        2'b10:   merge_data[15:8]  = wdata_q[7:0];
        default: merge_data[7:0]   = wdata_q[7:0];
      endcase
    end else if (off_q[1]) begin
      merge_data[15:0] = wdata_q;
    end else begin
      merge_data[31:16] = wdata_q;
    end
  end

  // Control FSM; every bus output is a register updated on state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      size_q         <= SZ_BYTE;
      off_q          <= 2'b00;
      uns_q          <= 1'b0;
      wdata_q        <= 16'h0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 32'h0;
      bus.mem_addr   <= 32'h0;
      bus.mem_wdata  <= 32'h0;
      bus.mem_write  <= 1'b0;
      bus.mem_read   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            size_q        <= bus.req_size;
            off_q         <= req_off;
            uns_q         <= bus.req_unsigned;
            wdata_q       <= bus.req_wdata[15:0];
            bus.req_ready <= 1'b0;
            if (req_err) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'h0;
            end else begin
              bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
              if (!bus.req_write) begin
                state        <= RD;
                bus.mem_read <= 1'b1;
              end else if (bus.req_size == SZ_WORD) begin
                state         <= WR;
                bus.mem_write <= 1'b1;
                bus.mem_wdata <= bus.req_wdata;
              end else begin
                state        <= RMW_RD;
                bus.mem_read <= 1'b1;
              end
            end
          end
        end
        RD: begin
          state          <= RESP;
          bus.mem_read   <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= load_data;
        end
        RMW_RD: begin
          state         <= WR;
          bus.mem_read  <= 1'b0;
          bus.mem_write <= 1'b1;
          bus.mem_wdata <= merge_data;
        end
        WR: begin
          state          <= RESP;
          bus.mem_write  <= 1'b0;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= 32'h0;
        end
        RESP: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= 32'h0;
        end
        default: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
          bus.resp_err   <= 1'b0;
          bus.mem_write  <= 1'b0;
          bus.mem_read   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-addressed big-endian reference memory predicts every response and memory write.
// Honors LSU_MISALIGN_TRAP_EN the same way as the design build.
module tb_lsu_ctrl;
  localparam int unsigned MEM_WORDS = 256;

  logic clk;
  logic reset;
  lsu_ctrl_if bus ();

  lsu_ctrl #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h8081_7F02;
    return (32'h9E37_79B9 * 32'(i)) ^ 32'h1234_5678;
  endfunction

  // Memory seen by the DUT, written only by its strobes
  logic [31:0] mem_arr [0:MEM_WORDS-1];
  logic        load_mem;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem_arr[i] <= init_word(i);
    end else if (bus.mem_write) begin
      mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = bus.mem_read ? mem_arr[bus.mem_addr[9:2]] : 32'hDEAD_BEEF;

  // Reference model: byte array, lowest address = most significant byte of a word
  logic [7:0] ref_b [0:4*MEM_WORDS-1];

  function automatic logic [31:0] ref_word(input int unsigned ba);
    return {ref_b[ba], ref_b[ba+1], ref_b[ba+2], ref_b[ba+3]};
  endfunction

  // Expectations for the transaction in flight
  bit          chk_en = 1'b0;
  bit          exp_active = 1'b0;
  int          cyc, exp_lat, exp_rd_cyc, exp_wr_cyc;
  logic        exp_err;
  logic [31:0] exp_rdata, exp_wdata, exp_maddr;
  logic [31:0] last_rdata;
  logic        last_err;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 32'h0);
      if (exp_active) begin
        cyc = cyc + 1;
        chk("resp_valid", 32'(bus.resp_valid), 32'(cyc == exp_lat));
        chk("req_ready", 32'(bus.req_ready), 32'(cyc > exp_lat));
        chk("mem_read", 32'(bus.mem_read), 32'(exp_rd_cyc != 0 && cyc == exp_rd_cyc));
        chk("mem_write", 32'(bus.mem_write), 32'(exp_wr_cyc != 0 && cyc == exp_wr_cyc));
        if (bus.mem_write) begin
          chk("mem_addr", bus.mem_addr, exp_maddr);
          chk("mem_wdata", bus.mem_wdata, exp_wdata);
        end
        if (bus.mem_read) chk("mem_addr_rd", bus.mem_addr, exp_maddr);
        if (cyc == exp_lat) begin
          chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
          chk("resp_rdata", bus.resp_rdata, exp_rdata);
          last_rdata = bus.resp_rdata;
          last_err   = bus.resp_err;
        end
        if (cyc > exp_lat) exp_active = 1'b0;
      end else begin
        chk("idle_ready", 32'(bus.req_ready), 32'h1);
        chk("idle_strobes", 32'({bus.resp_valid, bus.mem_read, bus.mem_write}), 32'h0);
      end
    end
  end

  // Predict outcome of one access from the reference memory (and apply stores to it)
  task automatic predict(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    int unsigned nb, ab;
    logic [31:0] v;
    exp_err = (sz == 2'b11) || ((a >> 2) >= MEM_WORDS);
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'b01 && (a % 2) != 0) exp_err = 1'b1;
    if (sz == 2'b10 && (a % 4) != 0) exp_err = 1'b1;
`endif
    exp_rdata  = 32'h0;
    exp_wdata  = 32'h0;
    exp_rd_cyc = 0;
    exp_wr_cyc = 0;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    ab = a - (a % nb);
    exp_maddr = ab - (ab % 4);
    if (exp_err) begin
      exp_lat = 1;
    end else if (!wr) begin
      exp_lat = 2;
      exp_rd_cyc = 1;
      v = 32'h0;
      for (int i = 0; i < int'(nb); i++) v = (v << 8) | 32'(ref_b[ab + i]);
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
      exp_rdata = v;
    end else begin
      for (int i = 0; i < int'(nb); i++) ref_b[ab + i] = 8'(wd >> (8*(nb - 1 - i)));
      exp_wdata  = ref_word(exp_maddr);
      exp_lat    = (nb == 4) ? 2 : 3;
      exp_wr_cyc = (nb == 4) ? 1 : 2;
      exp_rd_cyc = (nb == 4) ? 0 : 1;
    end
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    @(posedge clk);
    predict(wr, sz, uns, a, wd);
    cyc = 0;
    exp_active = 1'b1;
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_write    = ~wr;
    bus.req_size     = ~sz;
    bus.req_unsigned = ~uns;
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    repeat (exp_lat + 1) @(posedge clk);
  endtask

  int k1, k2, npulse, nbad;
  bit saw_bad;

  initial begin
    reset = 1'b1;
    load_mem = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]} = init_word(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    load_mem = 1'b0;
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_flags", 32'({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write}), 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_maddr", bus.mem_addr, 32'h0);
    chk("rst_mwdata", bus.mem_wdata, 32'h0);
    reset = 1'b0;
    chk_en = 1'b1;

    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("lit_lb_signed", last_rdata, 32'hFFFF_FF81);
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h1234_56AA);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lit_lw_after_sb", last_rdata, 32'h8081_AA02);
    do_req(1'b0, 2'b01, 1'b1, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lit_lhu_misalign_err", 32'(last_err), 32'h1);
`else
    chk("lit_lhu_forced", last_rdata, 32'h0000_AA02);
`endif
    do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h1111_2222);
    chk("lit_sw_range_err", 32'(last_err), 32'h1);
    do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    chk("lit_lbu", last_rdata, 32'h0000_0080);
    do_req(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("lit_lh_signed", last_rdata, 32'hFFFF_8081);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_BEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    do_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hA5A5_5A5A);
    do_req(1'b0, 2'b10, 1'b0, 32'h3FF, 32'h0);
    do_req(1'b0, 2'b00, 1'b0, 32'h400, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0);
    for (int off = 0; off < 4; off++) begin
      do_req(1'b1, 2'b00, 1'b0, 32'h14 + 32'(off), 32'(8'h10 + 8'(off)));
      do_req(1'b0, 2'b00, 1'b0, 32'h14 + 32'(off), 32'h0);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    chk("lit_lanes", last_rdata, 32'h1011_1213);
    do_req(1'b0, 2'b10, 1'b0, 32'h15, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h19, 32'h0000_C3D4);
    do_req(1'b0, 2'b01, 1'b0, 32'h1A, 32'h0);
    do_req(1'b0, 2'b01, 1'b1, 32'h18, 32'h0);

    // Back-to-back loads with req_valid held high
    chk_en = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size = 2'b10;
    bus.req_addr = 32'h10;
    k1 = 0; k2 = 0; npulse = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        npulse++;
        if (npulse == 1) k1 = k;
        if (npulse == 2) k2 = k;
      end
    end
    chk("b2b_first", 32'(k1), 32'd2);
    chk("b2b_second", 32'(k2), 32'd5);
    chk("b2b_count", 32'(npulse), 32'd2);
    repeat (3) @(negedge clk);

    // Reset during RMW_RD drops the store
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'b00;
    bus.req_addr = 32'h2C;
    bus.req_wdata = 32'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_rmw_in_rd", 32'(bus.mem_read), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_rmw_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_rmw_flags", 32'({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write}), 32'h0);
    chk("rst_rmw_regs", bus.mem_addr | bus.mem_wdata | bus.resp_rdata, 32'h0);
    saw_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem_write || bus.resp_valid) saw_bad = 1'b1;
    end
    chk("rst_rmw_quiet", 32'(saw_bad), 32'h0);

    // Reset during WR: the strobe covers the reset edge, then drops
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size = 2'b10;
    bus.req_addr = 32'h30;
    bus.req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_wr_strobe", 32'(bus.mem_write), 32'h1);
    {ref_b[32'h30], ref_b[32'h31], ref_b[32'h32], ref_b[32'h33]} = 32'hCAFE_F00D;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_wr_low", 32'({bus.mem_write, bus.resp_valid}), 32'h0);
    chk("rst_wr_ready", 32'(bus.req_ready), 32'h1);
    repeat (2) @(negedge clk);

    chk_en = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h2C, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    chk("lit_rst_wr_data", last_rdata, 32'hCAFE_F00D);

    nbad = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      if (mem_arr[i] !== ref_word(4*i)) nbad++;
    end
    chk("mem_final", 32'(nbad), 32'h0);
    chk("lit_word4", mem_arr[4], 32'h8081_AA02);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
